dm_result_checker: RTL and testbench

Synthesizable, parametrised self-check engine next to the CPU in `top`, connected to the DM port. It snoops DM writes for the finish-flag store and then stalls the CPU. It then streams a programmable number of DM words against a golden ROM, counts mismatches, and reports pass or fail. A cycle watchdog aborts runs that never finish. Mode 1 takes the check length from DM word 0, so the sort-style length rule runs in silicon or an FPGA without a simulator.

---
 rtl/chk_pkg.sv | 20 ++
 rtl/dm_result_checker_if.sv | 28 ++
 rtl/sat_counter.sv | 24 ++
 rtl/dm_result_checker.sv | 158 +++++++++++++++
 tb/tb_dm_result_checker.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chk_pkg.sv
// Shared types and constants for the DM result checker.
package chk_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        LEN   = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } chk_state_e;

    // Store value the program writes to the flag address when it finishes.
    localparam logic [31:0] DEFAULT_FLAG_VALUE = 32'hFFFF_F000;

    // How the number of checked words is chosen.
    localparam int CHK_FIXED        = 0;
    localparam int CHK_LEN_FROM_DM0 = 1;

endpackage

// File: rtl/dm_result_checker_if.sv
// DM snoop, DM read-back and golden ROM signals between the CPU top and the checker.
interface dm_result_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              DM_enable;
    logic              DM_write;
    logic [ADDR_W-1:0] DM_address;
    logic [DATA_W-1:0] DM_in;
    logic              hold_cpu;
    logic              chk_enable;
    logic [ADDR_W-1:0] chk_address;
    logic [DATA_W-1:0] chk_rdata;
    logic [ADDR_W-1:0] gold_address;
    logic [DATA_W-1:0] gold_rdata;

    // CPU top / memory side.
    modport master (
        output DM_enable, DM_write, DM_address, DM_in, chk_rdata, gold_rdata,
        input  hold_cpu, chk_enable, chk_address, gold_address
    );

    // Checker side.
    modport slave (
        input  DM_enable, DM_write, DM_address, DM_in, chk_rdata, gold_rdata,
        output hold_cpu, chk_enable, chk_address, gold_address
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] value
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    // Clear has priority; otherwise count up and hold at the ceiling.
    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (increment) begin
            value <= sat_inc(value);
        end
    end

endmodule

// File: rtl/dm_result_checker.sv
// Waits for the finish-flag store, stalls the CPU, then compares DM against a golden ROM.
module dm_result_checker
    import chk_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] FLAG_ADDR  = {ADDR_W{1'b1}},
    parameter logic [DATA_W-1:0] FLAG_VALUE = DATA_W'(DEFAULT_FLAG_VALUE),
    parameter int                CHECK_MODE = CHK_FIXED,
    parameter int                CHECK_LEN  = 32,
    parameter int                MAX_CYCLES = 10_000_000,
    parameter int                CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    dm_result_checker_if.slave dm,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [CNT_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam logic [ADDR_W:0]  LEN_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  LEN_FIXED = (ADDR_W+1)'(CHECK_LEN);
    localparam logic [CNT_W-1:0] WD_LIMIT  = CNT_W'(MAX_CYCLES - 1);

    // DM[0]*2+1 in ADDR_W+2 bits, clamped to the full address space.
    function automatic logic [ADDR_W:0] len_from_dm0(input logic [DATA_W-1:0] w);
        logic [ADDR_W+1:0] raw;
        if (|w[DATA_W-1:ADDR_W]) begin
            return LEN_MAX;
        end
        raw = {1'b0, w[ADDR_W-1:0], 1'b1};
        if (raw > {1'b0, LEN_MAX}) begin
            return LEN_MAX;
        end
        return raw[ADDR_W:0];
    endfunction

    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_cur;
    logic              len_pend_p1;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              issue;
    logic              hit;
    logic              wd_fire;
    logic              last_issue;
    logic              mismatch;

    assign hit = (state_q == RUN) && dm.DM_enable && dm.DM_write &&
                 (dm.DM_address == FLAG_ADDR) && (dm.DM_in == FLAG_VALUE);
    assign wd_fire = (state_q == RUN) && (cycle_count == WD_LIMIT);

    // In the first SCAN cycle of mode 1 the length arrives on chk_rdata this cycle.
    assign len_cur    = len_pend_p1 ? len_from_dm0(dm.chk_rdata) : len_q;
    assign last_issue = ({1'b0, idx_q} == (len_cur - LEN_ONE));
    assign mismatch   = vld_p1 && (dm.chk_rdata !== dm.gold_rdata);

    // Next-state and output decode; a flag hit outranks the watchdog.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        issue            = 1'b0;
        dm.hold_cpu      = 1'b0;
        dm.chk_enable    = 1'b0;
        dm.chk_address   = idx_q;
        dm.gold_address  = idx_q;
        done             = 1'b0;
        pass             = 1'b0;
        timeout          = 1'b0;
        case (state_q)
            RUN: begin
                if (hit) begin
                    state_d = (CHECK_MODE == CHK_LEN_FROM_DM0) ? LEN : SCAN;
                end else if (wd_fire) begin
                    state_d = ABORT;
                end
            end
            LEN: begin
                dm.hold_cpu    = 1'b1;
                dm.chk_enable  = 1'b1;
                dm.chk_address = '0;
                state_d        = SCAN;
            end
            SCAN: begin
                dm.hold_cpu   = 1'b1;
                dm.chk_enable = 1'b1;
                issue         = 1'b1;
                if (last_issue) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                dm.hold_cpu = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                dm.hold_cpu = 1'b1;
                done        = 1'b1;
                pass        = (err_count == '0);
            end
            ABORT: begin
                done    = 1'b1;
                timeout = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Control registers: state, scan index, length and the compare-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            idx_q          <= '0;
            len_q          <= '0;
            len_pend_p1    <= 1'b0;
            vld_p1         <= 1'b0;
            first_err_addr <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= (state_q == RUN) ? LEN_FIXED : len_cur;
            len_pend_p1 <= (state_q == LEN);
            vld_p1      <= issue;
            if (mismatch && (err_count == '0)) begin
                first_err_addr <= addr_p1;
            end
        end
    end

    // Issue -> compare stage: remember which address the returning pair belongs to.
    always_ff @(posedge clk) begin
        addr_p1 <= idx_q;
    end

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk       (clk),
        .clear     (rst),
        .increment (mismatch),
        .value     (err_count)
    );

    // The hit cycle itself is not counted, so cycle_count equals the hit cycle index.
    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk       (clk),
        .clear     (rst),
        .increment ((state_q == RUN) && !hit),
        .value     (cycle_count)
    );

endmodule

// File: tb/tb_dm_result_checker.sv
// Bench: three checker configurations with behavioural DM/golden memories.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_dm_result_checker;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dm_result_checker_if #(.DATA_W(32), .ADDR_W(16)) if0 ();
    dm_result_checker_if #(.DATA_W(32), .ADDR_W(8))  if1 ();
    dm_result_checker_if #(.DATA_W(32), .ADDR_W(16)) if2 ();

    logic        done0, pass0, to0, done1, pass1, to1, done2, pass2, to2;
    logic [31:0] err0, cnt0, err1, cnt1, err2, cnt2;
    logic [15:0] fea0, fea2;
    logic [7:0]  fea1;

    dm_result_checker #(.DATA_W(32), .ADDR_W(16), .FLAG_ADDR(16'hFFFF), .FLAG_VALUE(32'hFFFF_F000),
        .CHECK_MODE(0), .CHECK_LEN(32), .MAX_CYCLES(10_000_000), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .dm(if0), .done(done0), .pass(pass0), .timeout(to0),
        .err_count(err0), .first_err_addr(fea0), .cycle_count(cnt0));

    dm_result_checker #(.DATA_W(32), .ADDR_W(8), .FLAG_ADDR(8'hFF), .FLAG_VALUE(32'hFFFF_F000),
        .CHECK_MODE(1), .CHECK_LEN(32), .MAX_CYCLES(10_000_000), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .dm(if1), .done(done1), .pass(pass1), .timeout(to1),
        .err_count(err1), .first_err_addr(fea1), .cycle_count(cnt1));

    dm_result_checker #(.DATA_W(32), .ADDR_W(16), .FLAG_ADDR(16'hFFFF), .FLAG_VALUE(32'hFFFF_F000),
        .CHECK_MODE(0), .CHECK_LEN(4), .MAX_CYCLES(100), .CNT_W(32)) u2 (
        .clk(clk), .rst(rst), .dm(if2), .done(done2), .pass(pass2), .timeout(to2),
        .err_count(err2), .first_err_addr(fea2), .cycle_count(cnt2));

    logic [31:0] dm0 [256], gold0 [256];
    logic [31:0] dm1 [256], gold1 [256];
    logic [31:0] dm2 [256], gold2 [256];

    // Synchronous-read DM and golden ROMs: data valid one cycle after the address.
    always @(posedge clk) begin
        if (if0.chk_enable) if0.chk_rdata <= dm0[if0.chk_address[7:0]];
        if0.gold_rdata <= gold0[if0.gold_address[7:0]];
        if (if1.chk_enable) if1.chk_rdata <= dm1[if1.chk_address];
        if1.gold_rdata <= gold1[if1.gold_address];
        if (if2.chk_enable) if2.chk_rdata <= dm2[if2.chk_address[7:0]];
        if2.gold_rdata <= gold2[if2.gold_address[7:0]];
    end

    int rd0, rd1, zero1, max1;

    // Read-request monitors, cleared by reset.
    always @(posedge clk) begin
        if (rst) begin
            rd0 <= 0; rd1 <= 0; zero1 <= 0; max1 <= 0;
        end else begin
            if (if0.chk_enable) rd0 <= rd0 + 1;
            if (if1.chk_enable) begin
                rd1 <= rd1 + 1;
                if (if1.chk_address == 8'd0) zero1 <= zero1 + 1;
                if (int'(if1.chk_address) > max1) max1 <= int'(if1.chk_address);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive_dm(input int sel, input logic en, input logic we,
                            input logic [15:0] a, input logic [31:0] d);
        case (sel)
            0: begin if0.DM_enable = en; if0.DM_write = we; if0.DM_address = a; if0.DM_in = d; end
            1: begin if1.DM_enable = en; if1.DM_write = we; if1.DM_address = a[7:0]; if1.DM_in = d; end
            default: begin if2.DM_enable = en; if2.DM_write = we; if2.DM_address = a; if2.DM_in = d; end
        endcase
    endtask

    task automatic pulse_dm(input int sel, input logic en, input logic we,
                            input logic [15:0] a, input logic [31:0] d);
        drive_dm(sel, en, we, a, d);
        tick();
        drive_dm(sel, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    // Returns the cycle index in which done is first seen, or -1 if the budget expires.
    task automatic wait_done(input int sel, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            if (done_of(sel)) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    // Reference: mismatches among the first len words, and the lowest mismatching index.
    task automatic ref_model(input int sel, input int len, output int errs, output int first);
        logic [31:0] a, b;
        errs  = 0;
        first = 0;
        for (int i = 0; i < len; i++) begin
            case (sel)
                0: begin a = dm0[i]; b = gold0[i]; end
                1: begin a = dm1[i]; b = gold1[i]; end
                default: begin a = dm2[i]; b = gold2[i]; end
            endcase
            if (a !== b) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
    endtask

    task automatic fill_equal();
        for (int i = 0; i < 256; i++) begin
            dm0[i] = $urandom; gold0[i] = dm0[i];
            dm1[i] = $urandom; gold1[i] = dm1[i];
            dm2[i] = $urandom; gold2[i] = dm2[i];
        end
    endtask

    int at, e_err, e_first, p;

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) drive_dm(s, 1'b0, 1'b0, 16'h0, 32'h0);
        fill_equal();

        // Reset state.
        do_reset();
        `CHK("rst_hold", if0.hold_cpu, 1'b0)
        `CHK("rst_chk_en", if0.chk_enable, 1'b0)
        `CHK("rst_chk_addr", if0.chk_address, 16'h0)
        `CHK("rst_gold_addr", if0.gold_address, 16'h0)
        `CHK("rst_done", done0, 1'b0)
        `CHK("rst_pass", pass0, 1'b0)
        `CHK("rst_timeout", to0, 1'b0)
        `CHK("rst_err", err0, 32'h0)
        `CHK("rst_first", fea0, 16'h0)
        `CHK("rst_cycles", cnt0, 32'h0)

        // Mode 0, clean memory, flag at cycle 500.
        run_until(500);
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        `CHK("m0_hold_after_hit", if0.hold_cpu, 1'b1)
        wait_done(0, 100, at);
        `CHK("m0_done_cycle", at, 534)
        `CHK("m0_pass", pass0, 1'b1)
        `CHK("m0_err", err0, 32'd0)
        `CHK("m0_cycles", cnt0, 32'd500)
        `CHK("m0_reads", rd0, 32)
        `CHK("m0_timeout", to0, 1'b0)

        // Mode 0, DM[7] and DM[20] corrupted, plus a corruption beyond the checked range.
        do_reset();
        fill_equal();
        dm0[7]  = dm0[7] ^ 32'h0000_0100;
        dm0[20] = dm0[20] ^ 32'h8000_0000;
        dm0[40] = dm0[40] ^ 32'h1;
        ref_model(0, 32, e_err, e_first);
        run_until(40);
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        wait_done(0, 100, at);
        `CHK("m0e_done_cycle", at, 74)
        `CHK("m0e_err", int'(err0), e_err)
        `CHK("m0e_first", int'(fea0), e_first)
        `CHK("m0e_pass", pass0, 1'b0)

        // Mode 0, random corruptions.
        do_reset();
        fill_equal();
        for (int k = 0; k < 4; k++) begin
            p = int'($urandom_range(0, 31));
            dm0[p] = dm0[p] ^ (32'h1 << $urandom_range(0, 31));
        end
        ref_model(0, 32, e_err, e_first);
        run_until(17);
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        wait_done(0, 100, at);
        `CHK("m0r_done_cycle", at, 51)
        `CHK("m0r_err", int'(err0), e_err)
        `CHK("m0r_first", int'(fea0), e_first)
        `CHK("m0r_pass", pass0, (e_err == 0))

        // Near-miss accesses to the flag must not trigger.
        do_reset();
        fill_equal();
        run_until(10);
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F001);
        pulse_dm(0, 1'b1, 1'b0, 16'hFFFF, 32'hFFFF_F000);
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFE, 32'hFFFF_F000);
        pulse_dm(0, 1'b0, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        run_until(20);
        `CHK("nm_hold", if0.hold_cpu, 1'b0)
        `CHK("nm_done", done0, 1'b0)
        `CHK("nm_cycles", cnt0, 32'd20)
        `CHK("nm_reads", rd0, 0)

        // Reset pulsed mid-SCAN, then a clean re-check.
        dm0[2] = dm0[2] ^ 32'h10;
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        run_until(35);
        `CHK("ms_err_before_rst", err0, 32'd1)
        rst = 1'b1;
        tick();
        `CHK("ms_hold", if0.hold_cpu, 1'b0)
        `CHK("ms_chk_en", if0.chk_enable, 1'b0)
        `CHK("ms_chk_addr", if0.chk_address, 16'h0)
        `CHK("ms_gold_addr", if0.gold_address, 16'h0)
        `CHK("ms_done", done0, 1'b0)
        `CHK("ms_err", err0, 32'h0)
        `CHK("ms_first", fea0, 16'h0)
        `CHK("ms_cycles", cnt0, 32'h0)
        rst = 1'b0;
        cyc = 0;
        dm0[2] = gold0[2];
        run_until(40);
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        wait_done(0, 100, at);
        `CHK("ms_recheck_done", at, 74)
        `CHK("ms_recheck_pass", pass0, 1'b1)
        `CHK("ms_recheck_cycles", cnt0, 32'd40)

        // Unknown golden word counts as a mismatch.
        do_reset();
        fill_equal();
        gold0[3] = 'x;
        dm0[3]   = 32'h5A5A_1234;
        ref_model(0, 32, e_err, e_first);
        run_until(8);
        pulse_dm(0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        wait_done(0, 100, at);
        `CHK("x_err", int'(err0), e_err)
        `CHK("x_first", fea0, 16'd3)
        `CHK("x_pass", pass0, 1'b0)

        // Mode 1, DM[0]=5: one length read plus 11 scan reads at 0..10.
        do_reset();
        fill_equal();
        dm1[0] = 32'd5; gold1[0] = 32'd5;
        dm1[9] = dm1[9] ^ 32'h4;
        dm1[12] = dm1[12] ^ 32'h4;
        ref_model(1, 11, e_err, e_first);
        run_until(50);
        pulse_dm(1, 1'b1, 1'b1, 16'h00FF, 32'hFFFF_F000);
        wait_done(1, 100, at);
        `CHK("m1_done_cycle", at, 64)
        `CHK("m1_reads", rd1, 12)
        `CHK("m1_max_addr", max1, 10)
        `CHK("m1_err", int'(err1), e_err)
        `CHK("m1_first", int'(fea1), e_first)
        `CHK("m1_pass", pass1, 1'b0)

        // Mode 1, DM[0]=all-ones: length clamps to the whole address space without wrapping.
        do_reset();
        fill_equal();
        dm1[0] = 32'hFFFF_FFFF; gold1[0] = 32'hFFFF_FFFF;
        p = int'($urandom_range(1, 255));
        dm1[p] = ~dm1[p];
        ref_model(1, 256, e_err, e_first);
        run_until(20);
        pulse_dm(1, 1'b1, 1'b1, 16'h00FF, 32'hFFFF_F000);
        wait_done(1, 400, at);
        `CHK("m1s_done_cycle", at, 279)
        `CHK("m1s_reads", rd1, 257)
        `CHK("m1s_zero_reads", zero1, 2)
        `CHK("m1s_max_addr", max1, 255)
        `CHK("m1s_err", int'(err1), e_err)
        `CHK("m1s_first", int'(fea1), e_first)

        // Watchdog with no flag: abort in cycle 100.
        do_reset();
        fill_equal();
        run_until(99);
        `CHK("wd_done_early", done2, 1'b0)
        tick();
        `CHK("wd_done", done2, 1'b1)
        `CHK("wd_timeout", to2, 1'b1)
        `CHK("wd_pass", pass2, 1'b0)
        `CHK("wd_hold", if2.hold_cpu, 1'b0)
        pulse_dm(2, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        `CHK("wd_flag_ignored", if2.hold_cpu, 1'b0)

        // Flag and watchdog in the same cycle: the flag wins.
        do_reset();
        run_until(99);
        pulse_dm(2, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        wait_done(2, 50, at);
        `CHK("tie_done_cycle", at, 105)
        `CHK("tie_timeout", to2, 1'b0)
        `CHK("tie_pass", pass2, 1'b1)
        `CHK("tie_hold", if2.hold_cpu, 1'b1)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
